// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the inter-stage pipeline register: occupancy count and
// holding-state encoding ({skid valid, main valid}).
package pipe_stage_reg_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef logic [1:0] occupancy_t;

  // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } stage_state_e;

  function automatic occupancy_t occOf(stage_state_e s);
    occupancy_t occ;
    occ = {1'b0, s[0]} + {1'b0, s[1]};
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous reset; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE_STEP;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional 2-entry skid
// buffer, flush-to-bubble, and saturating transfer/flush counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush,
  pipe_stage_reg_if.slave         inBus,
  pipe_stage_reg_if.master        outBus,
  output occupancy_t              occupancy,
  output logic [CNT_W-1:0]        cnt_xfer,
  output logic [CNT_W-1:0]        cnt_flush
);

  stage_state_e      stateReg, stateNext;
  logic [DATA_W-1:0] mainReg, mainNext;
  logic [DATA_W-1:0] skidReg, skidNext;
  logic              mainValid, inReady, inFire, outFire;
  logic [1:0]        incVec;
  logic [CNT_W-1:0]  cntVec [2];

  assign mainValid = stateReg[0];
  // With the skid buffer, in_ready depends only on held state, breaking the
  // combinational ready chain through the pipeline.
  assign inReady   = (SKID != 0) ? (stateReg != FULL) : (!mainValid || outBus.ready);
  assign inFire    = inBus.valid && inReady;
  assign outFire   = mainValid && outBus.ready;

  always_comb begin
    stateNext = stateReg;
    mainNext  = mainReg;
    skidNext  = skidReg;
    if (flush) begin
      stateNext = EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        mainNext = '0;
        skidNext = '0;
      end
    end else begin
      case (stateReg)
        EMPTY: begin
          if (inFire) begin
            stateNext = ONE;
            mainNext  = inBus.data;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            mainNext = inBus.data;
          end else if (inFire) begin
            stateNext = FULL;
            skidNext  = inBus.data;
          end else if (outFire) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            stateNext = ONE;
            mainNext  = skidReg;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateReg <= EMPTY;
      mainReg  <= '0;
      skidReg  <= '0;
    end else begin
      stateReg <= stateNext;
      mainReg  <= mainNext;
      skidReg  <= skidNext;
    end
  end

  // Skid can only be valid alongside main, so mainValid means "any entry held".
  assign incVec = {flush && mainValid, outFire};

  for (genvar gi = 0; gi < 2; gi++) begin : gen_counters
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (incVec[gi]),
      .count (cntVec[gi])
    );
  end

  assign cnt_xfer      = cntVec[0];
  assign cnt_flush     = cntVec[1];
  assign inBus.ready   = inReady;
  assign outBus.valid  = mainValid;
  assign outBus.data   = mainReg;
  assign occupancy     = occOf(stateReg);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: FIFO-level queue model per instance checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flushA = 1'b0;
  logic flushB = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32)) inA ();
  pipe_stage_reg_if #(.DATA_W(32)) outA ();
  pipe_stage_reg_if #(.DATA_W(32)) inB ();
  pipe_stage_reg_if #(.DATA_W(32)) outB ();

  occupancy_t  occA, occB;
  logic [3:0]  xA, fA;
  logic [15:0] xB, fB;

  // A: skid buffer, clearing flush, narrow counters. B: plain register, payload held on flush.
  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(4)) dutA (
    .CLK(clk), .RST(rst), .flush(flushA), .inBus(inA), .outBus(outA),
    .occupancy(occA), .cnt_xfer(xA), .cnt_flush(fA));

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CLEAR_ON_FLUSH(0), .CNT_W(16)) dutB (
    .CLK(clk), .RST(rst), .flush(flushB), .inBus(inB), .outBus(outB),
    .occupancy(occB), .cnt_xfer(xB), .cnt_flush(fB));

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] qA[$], qB[$], logA[$], logB[$];
  int unsigned xferA, flA, xferB, flB;
  bit inFA, outFA, inFB, outFB;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: each stage is a FIFO of capacity 2 (A) or 1 (B) with flush emptying it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qA.delete(); qB.delete();
      xferA = 0; flA = 0; xferB = 0; flB = 0;
    end else begin
      inFA  = inA.valid && (qA.size() < 2);
      outFA = (qA.size() != 0) && outA.ready;
      inFB  = inB.valid && ((qB.size() == 0) || outB.ready);
      outFB = (qB.size() != 0) && outB.ready;
      if (outFA && xferA < 15) xferA++;
      if (outFB && xferB < 65535) xferB++;
      if (flushA) begin
        if (qA.size() != 0 && flA < 15) flA++;
        qA.delete();
      end else begin
        if (outFA) void'(qA.pop_front());
        if (inFA) qA.push_back(inA.data);
      end
      if (flushB) begin
        if (qB.size() != 0 && flB < 65535) flB++;
        qB.delete();
      end else begin
        if (outFB) void'(qB.pop_front());
        if (inFB) qB.push_back(inB.data);
      end
    end
  end

  always @(negedge clk) begin
    chk("A.out_valid", outA.valid, qA.size() != 0);
    chk("A.in_ready", inA.ready, qA.size() < 2);
    chk("A.occupancy", occA, qA.size());
    if (qA.size() != 0) chk("A.out_data", outA.data, qA[0]);
    chk("A.cnt_xfer", xA, xferA);
    chk("A.cnt_flush", fA, flA);
    chk("B.out_valid", outB.valid, qB.size() != 0);
    chk("B.in_ready", inB.ready, (qB.size() == 0) || outB.ready);
    chk("B.occupancy", occB, qB.size());
    if (qB.size() != 0) chk("B.out_data", outB.data, qB[0]);
    chk("B.cnt_xfer", xB, xferB);
    chk("B.cnt_flush", fB, flB);
    if (outA.valid && outA.ready) logA.push_back(outA.data);
    if (outB.valid && outB.ready) logB.push_back(outB.data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits;
    inA.valid = 0; inA.data = '0; outA.ready = 0;
    inB.valid = 0; inB.data = '0; outB.ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.A.out_valid", outA.valid, 0);
    chk("rst.A.out_data", outA.data, 0);
    chk("rst.A.in_ready", inA.ready, 1);
    chk("rst.A.occupancy", occA, 0);
    chk("rst.B.in_ready", inB.ready, 1);
    rst = 0;

    // Streaming with out_ready held high: one-cycle latency, full throughput.
    outA.ready = 1; logA.delete();
    for (int i = 0; i < 3; i++) begin
      inA.valid = 1; inA.data = 32'h100 + 32'(4 * i);
      step();
      chk("stream.latency", outA.data, 32'h100 + 32'(4 * i));
      chk("stream.occ", occA, 1);
    end
    inA.valid = 0; step();
    chk("stream.cnt_xfer", xA, 3);
    chk("stream.count", logA.size(), 3);
    chk("stream.last", logA[2], 32'h108);

    // Stall fill to FULL, a third push held off, then drain in order.
    outA.ready = 0; logA.delete();
    inA.valid = 1; inA.data = 32'hA; step();
    inA.data = 32'hB; step();
    chk("stall.occ_full", occA, 2);
    chk("stall.in_ready", inA.ready, 0);
    inA.data = 32'hC; step();
    chk("stall.hold_data", outA.data, 32'hA);
    chk("stall.hold_occ", occA, 2);
    outA.ready = 1; step(); step();
    inA.valid = 0; step();
    chk("stall.count", logA.size(), 3);
    chk("stall.order0", logA[0], 32'hA);
    chk("stall.order1", logA[1], 32'hB);
    chk("stall.order2", logA[2], 32'hC);
    chk("stall.cnt_xfer", xA, 6);

    // Flush while FULL, with a bundle presented the same cycle.
    outA.ready = 0; logA.delete();
    inA.valid = 1; inA.data = 32'h11; step();
    inA.data = 32'h12; step();
    chk("flush.pre_occ", occA, 2);
    inA.data = 32'hD; flushA = 1; step();
    flushA = 0; inA.valid = 0;
    chk("flush.out_valid", outA.valid, 0);
    chk("flush.occ", occA, 0);
    chk("flush.cleared", outA.data, 0);
    chk("flush.cnt_flush", fA, 1);

    // Flush in ONE state discards the simultaneous in_fire.
    inA.valid = 1; inA.data = 32'h21; step();
    inA.data = 32'hE; flushA = 1; step();
    flushA = 0; inA.valid = 0;
    chk("flush1.occ", occA, 0);
    chk("flush1.cnt_flush", fA, 2);

    // Flush on empty does not count.
    flushA = 1; step(); flushA = 0;
    chk("flush_empty.cnt_flush", fA, 2);

    // Flush coinciding with a downstream transfer still counts that transfer.
    inA.valid = 1; inA.data = 32'h31; step();
    inA.valid = 0; outA.ready = 1; flushA = 1; step();
    flushA = 0;
    chk("flush_xfer.cnt_xfer", xA, 7);
    chk("flush_xfer.cnt_flush", fA, 3);
    step(); step();
    hits = 0;
    foreach (logA[k]) if (logA[k] == 32'hD || logA[k] == 32'hE) hits++;
    chk("flush.squashed_absent", hits, 0);
    chk("flush_xfer.logged", logA.size(), 1);

    // Random handshake traffic, checked against the model each cycle.
    for (int i = 0; i < 40; i++) begin
      inA.valid = 1'($urandom_range(0, 1));
      inA.data = $urandom;
      outA.ready = 1'($urandom_range(0, 1));
      step();
    end

    // Counter saturation at 2^4-1.
    outA.ready = 1; inA.valid = 1;
    repeat (20) begin inA.data = $urandom; step(); end
    inA.valid = 0; step();
    chk("sat.cnt_xfer", xA, 15);

    // Asynchronous reset mid-stall clears everything immediately.
    outA.ready = 0; inA.valid = 1; inA.data = 32'h41; step();
    inA.data = 32'h42; step();
    inA.valid = 0;
    chk("rst_mid.pre_occ", occA, 2);
    #2 rst = 1;
    #1;
    chk("rst_mid.out_valid", outA.valid, 0);
    chk("rst_mid.occ", occA, 0);
    chk("rst_mid.out_data", outA.data, 0);
    chk("rst_mid.in_ready", inA.ready, 1);
    chk("rst_mid.cnt_xfer", xA, 0);
    chk("rst_mid.cnt_flush", fA, 0);
    step(); rst = 0; step();

    // SKID=0: combinational in_ready and back-to-back transfer.
    outB.ready = 0; inB.valid = 1; inB.data = 32'h55; step();
    inB.valid = 0;
    chk("B.stall_valid", outB.valid, 1);
    chk("B.stall_in_ready", inB.ready, 0);
    logB.delete();
    outB.ready = 1; #1;
    chk("B.comb_in_ready", inB.ready, 1);
    inB.valid = 1; inB.data = 32'h56; step();
    inB.data = 32'h57; step();
    inB.valid = 0; step();
    chk("B.count", logB.size(), 3);
    chk("B.order0", logB[0], 32'h55);
    chk("B.order1", logB[1], 32'h56);
    chk("B.order2", logB[2], 32'h57);
    chk("B.cnt_xfer", xB, 3);

    // CLEAR_ON_FLUSH=0: payload held, only valid dropped.
    outB.ready = 0; inB.valid = 1; inB.data = 32'h77; step();
    inB.valid = 0; flushB = 1; step(); flushB = 0;
    chk("B.flush_valid", outB.valid, 0);
    chk("B.flush_held", outB.data, 32'h77);
    chk("B.cnt_flush", fB, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the generalised successor of the fixed per-stage latch interfaces (e.g. MEM/WB). Carries an opaque payload bundle between two pipeline stages with a valid/ready handshake, optional 2-entry skid buffering, and flush (bubble insertion). Saturating transfer and flush counters feed the performance-counter block. Every stage boundary (IF/ID through MEM/WB) instantiates it.

Parameters:
DATA_W, 32, payload width in bits (packed stage bundle: instr, pc, control, result).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CLEAR_ON_FLUSH, 1, 1 = payload registers zeroed on flush (NOP bundle); 0 = payload held, only valid bits cleared.
CNT_W, 16, width of the saturating performance counters.

Ports:
CLK  input  1  system clock, rising-edge.
RST  input  1  asynchronous, active-high reset.
flush  input  1  squash all held entries this cycle (branch/jump resolution).
in_valid  input  1  upstream stage presents a valid bundle.
in_ready  output  1  this stage can accept a bundle.
in_data  input  DATA_W  upstream bundle.
out_valid  output  1  bundle available to downstream stage.
out_ready  input  1  downstream stage accepts (0 = stall).
out_data  output  DATA_W  bundle to downstream stage.
occupancy  output  2  entries held (0..2; max 1 when SKID=0).
cnt_xfer  output  CNT_W  count of downstream transfers (out_valid & out_ready).
cnt_flush  output  CNT_W  count of cycles in which flush squashed at least one valid entry.

Behaviour:
- Reset (RST=1, async): main/skid valid=0, payloads=0, counters=0; out_valid=0, out_data=0, occupancy=0; in_ready=1 (SKID=1) or =1 via comb path (SKID=0).
- Fire terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle in_data -> out_data when not stalled; full throughput (one bundle/cycle) with out_ready held high.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). On in_fire, main <= in_data, valid<=1; else on out_fire valid<=0; else hold.
- SKID=1: in_ready = ~skid_valid (register output only, no comb path from out_ready).
  * States by (main_v, skid_v): EMPTY(0,0), ONE(1,0), FULL(1,1).
  * EMPTY: in_fire -> ONE, main<=in_data.
  * ONE: in_fire & out_fire -> ONE, main<=in_data; in_fire & ~out_fire -> FULL, skid<=in_data; ~in_fire & out_fire -> EMPTY; else hold.
  * FULL: in_ready=0; out_fire -> ONE, main<=skid; else hold.
  * Ordering strictly FIFO; no bundle duplicated or dropped absent flush.
- out_valid=main_v; out_data=main payload; occupancy=main_v+skid_v.
- Stall: out_ready=0 holds out_data/out_valid stable cycle-to-cycle (AXI-style: valid never retracted without flush).
- Flush (highest priority): next cycle main_v=skid_v=0; simultaneous in_fire is discarded (upstream treats it as squashed); simultaneous out_fire still counts as a transfer (downstream consumed it this cycle). CLEAR_ON_FLUSH=1 zeroes both payloads.
- cnt_xfer += 1 on out_fire; cnt_flush += 1 when flush & (main_v|skid_v); both saturate at 2^CNT_W-1 (no wrap).
- RST asserted mid-transfer: all state cleared immediately; bundles in flight lost by definition.

Decomposition:
- cpu_types_pkg: stage bundle struct typedefs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t) whose $bits sets DATA_W; occupancy_t.
- One sub-module: sat_counter (CNT_W, inc, CLK, RST -> count), instantiated twice.
- Per-stage *_if interfaces keep modports; this block sits behind them.

Test Plan:
- Streaming: SKID=1, out_ready=1, in_data=0x100,0x104,0x108 on consecutive cycles -> out_data same sequence each 1 cycle later, cnt_xfer=3, occupancy<=1.
- Stall fill: out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0 on cycle after 0xB; push 0xC held off; release out_ready -> out 0xA,0xB,0xC in order.
- Flush with FULL state: occupancy=2, flush=1 and in_fire 0xD same cycle -> next cycle out_valid=0, occupancy=0, out_data=0 (CLEAR_ON_FLUSH=1), cnt_flush=1, 0xD never appears.
- Flush on empty: occupancy=0, flush=1 -> cnt_flush unchanged (0).
- SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 combinationally, back-to-back transfer.
- Saturation/reset: CNT_W=4, 20 transfers -> cnt_xfer=15; assert RST mid-stall with occupancy=2 -> all outputs 0 immediately, in_ready=1.
